we_next_rr_arbiter: RTL and testbench

- Shares one `we`/`next` downstream consumer (e.g. `reciver`) between NUM_SRC producers (e.g. `sender` instances), each using the same `we`/`next` handshake.
- A word transfers on a port when `we && next` is high at a rising clk edge.
- The block picks one requester round-robin and locks the grant onto it for up to MAX_BURST transfers. It muxes that requester's data onto the single output port and routes `next` back to the granted source only.

---
 rtl/we_next_rr_arbiter_pkg.sv | 18 +
 rtl/we_next_rr_arbiter_if.sv | 27 ++
 rtl/we_next_rr_arbiter_rr_pick.sv | 31 +++
 rtl/we_next_rr_arbiter.sv | 108 ++++++++++
 tb/tb_we_next_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/we_next_rr_arbiter_pkg.sv
// Shared types and helpers for the we/next round-robin arbiter.
package we_next_pkg;

  // Arbiter control state: waiting for a request, or locked onto one source.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Burst counter width; wide enough for MAX_BURST up to 15.
  localparam int BURST_CNT_W = 4;

  // Index arithmetic that wraps at the number of sources, not at a power of two.
  function automatic int wrap_add(int base, int off, int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/we_next_rr_arbiter_if.sv
// Bundle of the per-source request side and the single downstream port.
// 'master' is the arbiter's view (drives accepts, downstream write and grant
// status); 'slave' is the surrounding environment's view.
interface we_next_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 8,
  parameter int IDW     = 2
);
  logic [NUM_SRC-1:0]    ai_we;
  logic [NUM_SRC*DW-1:0] ai_data;
  logic [NUM_SRC-1:0]    ao_next;
  logic                  ao_we;
  logic [DW-1:0]         ao_data;
  logic                  ai_next;
  logic                  ao_gnt_vld;
  logic [IDW-1:0]        ao_gnt_id;

  modport master (
    input  ai_we, ai_data, ai_next,
    output ao_next, ao_we, ao_data, ao_gnt_vld, ao_gnt_id
  );

  modport slave (
    output ai_we, ai_data, ai_next,
    input  ao_next, ao_we, ao_data, ao_gnt_vld, ao_gnt_id
  );
endinterface

// File: rtl/we_next_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping at
// NUM_SRC. Purely combinational.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);
  import we_next_pkg::*;

  // cand[k] is the source examined k-th; req_rot[k] is its request bit.
  logic [IDW-1:0]     cand [NUM_SRC];
  logic [NUM_SRC-1:0] req_rot;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
    assign cand[gi]    = IDW'(wrap_add(int'(ptr), gi, NUM_SRC));
    assign req_rot[gi] = req[cand[gi]];
  end

  // Lowest rotated position wins, so scan from the far end down to ptr.
  always_comb begin
    any = |req_rot;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) idx = cand[k];
    end
  end
endmodule

// File: rtl/we_next_rr_arbiter.sv
// Round-robin arbiter sharing one we/next consumer between NUM_SRC producers.
// A grant is held for up to MAX_BURST transfers or until the source drops we.
module we_next_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  we_next_rr_arbiter_if.master bus
);
  import we_next_pkg::*;

  state_t                 state_reg, state_next;
  logic [IDW-1:0]         ptr_reg, ptr_next;
  logic [IDW-1:0]         gnt_id_reg, gnt_id_next;
  logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

  logic                   pick_any;
  logic [IDW-1:0]         pick_idx;
  logic [DW-1:0]          src_data [NUM_SRC];
  logic                   gnt_we;
  logic                   last_beat;
  logic [IDW-1:0]         ptr_after;

  // Unpack the flat data bus into one word per source.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_data[gi] = bus.ai_data[gi*DW +: DW];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_pick (
    .req (bus.ai_we),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_we    = bus.ai_we[gnt_id_reg];
  assign last_beat = (burst_cnt_reg == BURST_CNT_W'(MAX_BURST - 1));
  // Next search starts just past the source that is giving up the grant.
  assign ptr_after = IDW'(wrap_add(int'(gnt_id_reg), 1, NUM_SRC));

  // State register; reset aborts any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gnt_id_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_id_reg    <= gnt_id_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_id_next    = gnt_id_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          gnt_id_next    = pick_idx;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_we) begin
          // Source ran dry: release without a transfer.
          state_next = IDLE;
          ptr_next   = ptr_after;
        end else if (bus.ai_next) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (last_beat) begin
            state_next = IDLE;
            ptr_next   = ptr_after;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: mux the granted source downstream and route next back to it only.
  always_comb begin
    bus.ao_we      = 1'b0;
    bus.ao_data    = '0;
    bus.ao_next    = '0;
    bus.ao_gnt_vld = 1'b0;
    bus.ao_gnt_id  = '0;
    if (state_reg == GRANT) begin
      bus.ao_gnt_vld          = 1'b1;
      bus.ao_gnt_id           = gnt_id_reg;
      bus.ao_we               = gnt_we;
      bus.ao_data             = src_data[gnt_id_reg];
      bus.ao_next[gnt_id_reg] = bus.ai_next;
    end
  end
endmodule

// File: tb/tb_we_next_rr_arbiter.sv
// Bench for the we/next round-robin arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_we_next_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  we_next_rr_arbiter_if #(.NUM_SRC(N), .DW(DW), .IDW(2)) bus ();

  we_next_rr_arbiter #(
    .NUM_SRC   (N),
    .DW        (DW),
    .MAX_BURST (MB),
    .IDW       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Sender side: each source's current word; advances after it is accepted.
  logic [DW-1:0] src_data [N];
  logic [N-1:0]  xf;
  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign bus.ai_data[gi*DW +: DW] = src_data[gi];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner = granted source (-1 none), sent = beats in this grant,
  // start = where the next search begins.
  int owner = -1;
  int start = 0;
  int sent  = 0;
  bit model_ok = 1'b0;

  initial begin
    logic [N-1:0]  e_next;
    logic [DW-1:0] e_data;
    int            s;
    bit            found;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        e_next = '0;
        e_data = '0;
        if (owner >= 0) begin
          e_next[owner] = bus.ai_next;
          e_data        = src_data[owner];
        end
        chk("m_vld",  32'(bus.ao_gnt_vld), 32'(owner >= 0));
        chk("m_we",   32'(bus.ao_we), 32'((owner >= 0) && bus.ai_we[owner]));
        chk("m_data", 32'(bus.ao_data), 32'(e_data));
        chk("m_next", 32'(bus.ao_next), 32'(e_next));
        chk("m_onehot", 32'($countones(bus.ao_next) <= 1), 32'd1);
        if (owner >= 0) chk("m_id", 32'(bus.ao_gnt_id), 32'(owner));
        if (bus.ao_gnt_vld && bus.ao_we && bus.ai_next && !rst)
          $display("xfer src=%0d data=%0d t=%0t", bus.ao_gnt_id, bus.ao_data, $time);
      end
      // Advance the model to what the coming clock edge must produce.
      if (rst) begin
        owner = -1; start = 0; sent = 0; model_ok = 1'b1;
      end else if (model_ok) begin
        if (owner < 0) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            s = (start + k) % N;
            if (!found && bus.ai_we[s]) begin
              owner = s; sent = 0; found = 1'b1;
            end
          end
        end else if (!bus.ai_we[owner]) begin
          start = (owner + 1) % N; owner = -1;
        end else if (bus.ai_next) begin
          sent++;
          if (sent == MB) begin
            start = (owner + 1) % N; owner = -1;
          end
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    xf = rst ? '0 : (bus.ai_we & bus.ao_next);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xf[i]) src_data[i] = src_data[i] + 1'b1;
    xf = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.ai_we = '0; bus.ai_next = 1'b0;
    sample(); tick(); sample(); tick();
    rst = 1'b0;
  endtask

  int t2_vld  [6] = '{1, 1, 1, 1, 0, 1};
  int t2_data [6] = '{88, 89, 90, 91, 0, 92};
  int t4_data [4] = '{88, 89, 90, 91};

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.ai_we = 4'hF; bus.ai_next = 1'b1; xf = '0;
    for (int i = 0; i < N; i++) src_data[i] = 8'(i * 16);

    // Reset held with every source requesting.
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      chk("rst_we", 32'(bus.ao_we), 0);
      chk("rst_next", 32'(bus.ao_next), 0);
      chk("rst_vld", 32'(bus.ao_gnt_vld), 0);
      chk("rst_data", 32'(bus.ao_data), 0);
      chk("rst_id", 32'(bus.ao_gnt_id), 0);
    end
    tick(); rst = 1'b0;
    sample(); chk("post_rst_idle", 32'(bus.ao_gnt_vld), 0);
    tick(); sample();
    chk("first_vld", 32'(bus.ao_gnt_vld), 1);
    chk("first_id", 32'(bus.ao_gnt_id), 0);
    tick();

    // Single source, full bursts with one idle cycle between grants.
    do_reset();
    src_data[2] = 8'd88; bus.ai_we = 4'b0100; bus.ai_next = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      sample();
      chk("single_vld", 32'(bus.ao_gnt_vld), 32'(t2_vld[c]));
      chk("single_data", 32'(bus.ao_data), 32'(t2_data[c]));
      if (t2_vld[c] == 1) chk("single_id", 32'(bus.ao_gnt_id), 2);
      tick();
    end

    // All sources requesting: rotation 0,1,2,3,0 with four beats each.
    do_reset();
    bus.ai_we = 4'hF; bus.ai_next = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      sample();
      if (c % 5 == 4) begin
        chk("rot_gap", 32'(bus.ao_gnt_vld), 0);
      end else begin
        chk("rot_vld", 32'(bus.ao_gnt_vld), 1);
        chk("rot_id", 32'(bus.ao_gnt_id), 32'((c / 5) % 4));
      end
      tick();
    end

    // Back-pressure: stalled beats do not count toward the burst.
    do_reset();
    src_data[1] = 8'd88; bus.ai_we = 4'b0010; bus.ai_next = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("bp_we", 32'(bus.ao_we), 1);
      chk("bp_data", 32'(bus.ao_data), 88);
      chk("bp_next", 32'(bus.ao_next), 0);
      chk("bp_id", 32'(bus.ao_gnt_id), 1);
      tick();
    end
    bus.ai_next = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (c < 4) begin
        chk("bp_go_data", 32'(bus.ao_data), 32'(t4_data[c]));
        chk("bp_go_next", 32'(bus.ao_next), 32'h2);
      end else begin
        chk("bp_release", 32'(bus.ao_gnt_vld), 0);
      end
      tick();
    end

    // Early drop by source 3 after two beats; source 1 wins next.
    do_reset();
    src_data[3] = 8'd200; bus.ai_we = 4'b1000; bus.ai_next = 1'b1;
    tick();
    bus.ai_we = 4'b1010;
    sample(); chk("drop_id", 32'(bus.ao_gnt_id), 3); chk("drop_d0", 32'(bus.ao_data), 200);
    tick();
    sample(); chk("drop_d1", 32'(bus.ao_data), 201);
    tick();
    bus.ai_we = 4'b0010;
    sample(); chk("drop_we", 32'(bus.ao_we), 0); chk("drop_vld", 32'(bus.ao_gnt_vld), 1);
    tick();
    bus.ai_we = 4'b1010;
    sample(); chk("drop_idle", 32'(bus.ao_gnt_vld), 0);
    tick();
    sample(); chk("drop_next_id", 32'(bus.ao_gnt_id), 1);
    tick();

    // Mid-burst reset: move ptr to 3 first, then reset during source 1's burst.
    do_reset();
    src_data[1] = 8'd40; bus.ai_we = 4'b0100; bus.ai_next = 1'b1;
    tick();
    bus.ai_we = 4'b0010;
    sample(); chk("mr_drop_id", 32'(bus.ao_gnt_id), 2);
    tick();
    sample(); chk("mr_idle", 32'(bus.ao_gnt_vld), 0);
    tick();
    sample(); chk("mr_id", 32'(bus.ao_gnt_id), 1); chk("mr_d0", 32'(bus.ao_data), 40);
    tick();
    rst = 1'b1;
    sample(); chk("mr_d1", 32'(bus.ao_data), 41);
    tick();
    rst = 1'b0; bus.ai_we = 4'b1011;
    sample();
    chk("mr_vld", 32'(bus.ao_gnt_vld), 0);
    chk("mr_we", 32'(bus.ao_we), 0);
    chk("mr_next", 32'(bus.ao_next), 0);
    chk("mr_data", 32'(bus.ao_data), 0);
    tick();
    sample(); chk("mr_restart_id", 32'(bus.ao_gnt_id), 0); chk("mr_restart_vld", 32'(bus.ao_gnt_vld), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
